// File: rtl/raster_scan_engine.sv
// ---------------------------------------------------------------------------
// raster_scan_engine
//
// Triangle rasterizer scan engine. Walks the clamped bounding box of a
// triangle, LANES horizontally adjacent pixels per cycle. The three edge
// functions E_i(x,y) = a_i*x + b_i*y + c_i are evaluated incrementally, so the
// scan loop only adds. Multiplies happen once per triangle, in SETUP.
//
// Each covered beat goes out through a one-entry output register with a
// valid/ready handshake.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   start, abort        launch a triangle (IDLE only) / cancel the current one
//   busy, done          engine active / 1-cycle pulse at completion
//   bound_coefs[i][0]   a_i (x coefficient), [i][1] b_i (y coefficient), signed
//   bound_const[i]      c_i, signed, 2*COORD_WIDTH bits
//   bbox_x0/x1/y0/y1    inclusive bounding box, unsigned
//   winding_any         1: accept either winding, 0: only all E >= 0
//   color               flat triangle color
//   out_valid/out_ready beat handshake
//   out_addr            y*SCREEN_X_SIZE + x of lane 0
//   out_mask            bit k set when pixel x+k is covered
//   out_color           color of the beat
// ---------------------------------------------------------------------------
module raster_scan_engine #(
    parameter int COORD_WIDTH   = 16,
    parameter int COLOR_WIDTH   = 16,
    parameter int SCREEN_X_SIZE = 800,
    parameter int SCREEN_Y_SIZE = 600,
    parameter int LANES         = 4,
    parameter int BUFFER_ADDR_W = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  abort,
    output logic                                  busy,
    output logic                                  done,
    input  logic [2:0][1:0][COORD_WIDTH-1:0]      bound_coefs,
    input  logic [2:0][2*COORD_WIDTH-1:0]         bound_const,
    input  logic [COORD_WIDTH-1:0]                bbox_x0,
    input  logic [COORD_WIDTH-1:0]                bbox_x1,
    input  logic [COORD_WIDTH-1:0]                bbox_y0,
    input  logic [COORD_WIDTH-1:0]                bbox_y1,
    input  logic                                  winding_any,
    input  logic [COLOR_WIDTH-1:0]                color,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [BUFFER_ADDR_W-1:0]              out_addr,
    output logic [LANES-1:0]                      out_mask,
    output logic [COLOR_WIDTH-1:0]                out_color
);

    // Wide enough that a*x + b*y + c can never overflow.
    localparam int EW = 2*COORD_WIDTH + 4;
    // One extra bit so that x + LANES cannot wrap around.
    localparam int XW = COORD_WIDTH + 1;

    localparam logic [COORD_WIDTH-1:0] X_MAX = COORD_WIDTH'(SCREEN_X_SIZE - 1);
    localparam logic [COORD_WIDTH-1:0] Y_MAX = COORD_WIDTH'(SCREEN_Y_SIZE - 1);
    localparam logic [COORD_WIDTH-1:0] ALIGN = ~COORD_WIDTH'(LANES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t state_reg;

    // Triangle captured on start
    logic signed [COORD_WIDTH-1:0]   a_reg [3];
    logic signed [COORD_WIDTH-1:0]   b_reg [3];
    logic signed [2*COORD_WIDTH-1:0] c_reg [3];
    logic [COORD_WIDTH-1:0]          x0_reg, x1_reg, y0_reg, y1_reg, xs_reg;
    logic                            wind_reg;
    logic [COLOR_WIDTH-1:0]          color_reg;

    // Scan state
    logic [COORD_WIDTH-1:0]          x_reg, y_reg;
    logic [BUFFER_ADDR_W-1:0]        base_reg;
    logic signed [EW-1:0]            e_reg     [3];  // E at (x, y), lane 0
    logic signed [EW-1:0]            e_row_reg [3];  // E at (xs, y)
    logic signed [EW-1:0]            step_reg  [3];  // a_i * LANES
    logic signed [EW-1:0]            off_reg   [3][LANES];  // a_i * k

    function automatic logic signed [EW-1:0] sext_coord(input logic [COORD_WIDTH-1:0] v);
        return $signed({{(EW-COORD_WIDTH){v[COORD_WIDTH-1]}}, v});
    endfunction

    function automatic logic signed [EW-1:0] zext_coord(input logic [COORD_WIDTH-1:0] v);
        return $signed({{(EW-COORD_WIDTH){1'b0}}, v});
    endfunction

    function automatic logic signed [EW-1:0] sext_const(input logic [2*COORD_WIDTH-1:0] v);
        return $signed({{(EW-2*COORD_WIDTH){v[2*COORD_WIDTH-1]}}, v});
    endfunction

    // Row-start edge values, used only in SETUP.
    logic signed [EW-1:0] e_init [3];
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge_init
        assign e_init[gi] = sext_coord(a_reg[gi]) * zext_coord(xs_reg)
                          + sext_coord(b_reg[gi]) * zext_coord(y0_reg)
                          + sext_const(c_reg[gi]);
    end

    logic box_empty;
    assign box_empty = (x0_reg > x1_reg) || (y0_reg > y1_reg)
                    || ({1'b0, x0_reg} >= XW'(SCREEN_X_SIZE))
                    || ({1'b0, y0_reg} >= XW'(SCREEN_Y_SIZE));

    logic row_end;
    assign row_end = ({1'b0, x_reg} + XW'(LANES)) > {1'b0, x1_reg};

    // Per-lane coverage test on the current beat.
    logic [LANES-1:0] lane_mask;
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [EW-1:0] le0, le1, le2;
        logic [XW-1:0]        px;
        logic                 all_ge, all_le, in_box;

        assign le0    = e_reg[0] + off_reg[0][gi];
        assign le1    = e_reg[1] + off_reg[1][gi];
        assign le2    = e_reg[2] + off_reg[2][gi];
        assign px     = {1'b0, x_reg} + XW'(gi);
        assign all_ge = !le0[EW-1] && !le1[EW-1] && !le2[EW-1];
        assign all_le = (le0[EW-1] || (le0 == '0))
                     && (le1[EW-1] || (le1 == '0))
                     && (le2[EW-1] || (le2 == '0));
        assign in_box = (px >= {1'b0, x0_reg}) && (px <= {1'b0, x1_reg});
        assign lane_mask[gi] = in_box && (all_ge || (wind_reg && all_le));
    end

    // The scan only moves when the output register can take a new beat.
    logic advance;
    assign advance = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_mask  <= '0;
            out_color <= '0;
            x0_reg    <= '0;
            x1_reg    <= '0;
            y0_reg    <= '0;
            y1_reg    <= '0;
            xs_reg    <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            wind_reg  <= 1'b0;
            color_reg <= '0;
            base_reg  <= '0;
            for (int i = 0; i < 3; i++) begin
                a_reg[i]     <= '0;
                b_reg[i]     <= '0;
                c_reg[i]     <= '0;
                e_reg[i]     <= '0;
                e_row_reg[i] <= '0;
                step_reg[i]  <= '0;
                for (int k = 0; k < LANES; k++) begin
                    off_reg[i][k] <= '0;
                end
            end
        end else if (abort) begin
            // Abort also suppresses a start in the same IDLE cycle.
            state_reg <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < 3; i++) begin
                            a_reg[i] <= $signed(bound_coefs[i][0]);
                            b_reg[i] <= $signed(bound_coefs[i][1]);
                            c_reg[i] <= $signed(bound_const[i]);
                        end
                        x0_reg    <= bbox_x0;
                        x1_reg    <= (bbox_x1 > X_MAX) ? X_MAX : bbox_x1;
                        y0_reg    <= bbox_y0;
                        y1_reg    <= (bbox_y1 > Y_MAX) ? Y_MAX : bbox_y1;
                        xs_reg    <= bbox_x0 & ALIGN;
                        wind_reg  <= winding_any;
                        color_reg <= color;
                        busy      <= 1'b1;
                        state_reg <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    for (int i = 0; i < 3; i++) begin
                        e_reg[i]     <= e_init[i];
                        e_row_reg[i] <= e_init[i];
                        step_reg[i]  <= sext_coord(a_reg[i]) * $signed(EW'(LANES));
                        for (int k = 0; k < LANES; k++) begin
                            off_reg[i][k] <= sext_coord(a_reg[i]) * $signed(EW'(k));
                        end
                    end
                    x_reg    <= xs_reg;
                    y_reg    <= y0_reg;
                    base_reg <= BUFFER_ADDR_W'(y0_reg) * BUFFER_ADDR_W'(SCREEN_X_SIZE);
                    if (box_empty) begin
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        state_reg <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (advance) begin
                        // Beats with no covered lane are dropped here.
                        if (|lane_mask) begin
                            out_valid <= 1'b1;
                            out_addr  <= base_reg + BUFFER_ADDR_W'(x_reg);
                            out_mask  <= lane_mask;
                            out_color <= color_reg;
                        end
                        if (row_end) begin
                            if (y_reg == y1_reg) begin
                                state_reg <= S_DRAIN;
                            end else begin
                                x_reg    <= xs_reg;
                                y_reg    <= y_reg + 1'b1;
                                base_reg <= base_reg + BUFFER_ADDR_W'(SCREEN_X_SIZE);
                                for (int i = 0; i < 3; i++) begin
                                    e_row_reg[i] <= e_row_reg[i] + sext_coord(b_reg[i]);
                                    e_reg[i]     <= e_row_reg[i] + sext_coord(b_reg[i]);
                                end
                            end
                        end else begin
                            x_reg <= x_reg + COORD_WIDTH'(LANES);
                            for (int i = 0; i < 3; i++) begin
                                e_reg[i] <= e_reg[i] + step_reg[i];
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    // Leave once the last beat is gone (or leaves this cycle).
                    if (!out_valid || out_ready) begin
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end

                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raster_scan_engine.sv
module tb_raster_scan_engine;

    localparam int CW = 16;
    localparam int KW = 16;
    localparam int SX = 800;
    localparam int SY = 600;
    localparam int L  = 4;
    localparam int AW = 32;

    logic                        clk = 1'b0;
    logic                        reset, start, abort;
    logic                        busy, done;
    logic [2:0][1:0][CW-1:0]     bound_coefs;
    logic [2:0][2*CW-1:0]        bound_const;
    logic [CW-1:0]               bbox_x0, bbox_x1, bbox_y0, bbox_y1;
    logic                        winding_any;
    logic [KW-1:0]               color;
    logic                        out_valid, out_ready;
    logic [AW-1:0]               out_addr;
    logic [L-1:0]                out_mask;
    logic [KW-1:0]               out_color;

    always #5 clk = ~clk;

    raster_scan_engine #(
        .COORD_WIDTH(CW), .COLOR_WIDTH(KW), .SCREEN_X_SIZE(SX),
        .SCREEN_Y_SIZE(SY), .LANES(L), .BUFFER_ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .bound_coefs(bound_coefs), .bound_const(bound_const),
        .bbox_x0(bbox_x0), .bbox_x1(bbox_x1), .bbox_y0(bbox_y0), .bbox_y1(bbox_y1),
        .winding_any(winding_any), .color(color),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_mask(out_mask), .out_color(out_color)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Current triangle (reference copy, independent of DUT inputs)
    int ta[3], tb[3], tc[3];
    int tx0, tx1, ty0, ty1;
    bit twind;
    int tcolor;

    int unsigned   exp_addr[$];
    int            exp_mask[$];
    logic [AW-1:0] got_addr[$];
    logic [L-1:0]  got_mask[$];
    logic [KW-1:0] got_color[$];
    int            got_edge[$];

    // ---------------- stimulus helpers ----------------
    task automatic set_tri_flat(input int c, input int x0, input int x1,
                                input int y0, input int y1, input bit w);
        for (int i = 0; i < 3; i++) begin
            ta[i] = 0; tb[i] = 0; tc[i] = c;
        end
        tx0 = x0; tx1 = x1; ty0 = y0; ty1 = y1; twind = w;
        tcolor = int'($urandom_range(0, 65535));
    endtask

    task automatic apply_tri();
        for (int i = 0; i < 3; i++) begin
            bound_coefs[i][0] = CW'(ta[i]);
            bound_coefs[i][1] = CW'(tb[i]);
            bound_const[i]    = (2*CW)'(tc[i]);
        end
        bbox_x0 = CW'(tx0); bbox_x1 = CW'(tx1);
        bbox_y0 = CW'(ty0); bbox_y1 = CW'(ty1);
        winding_any = twind;
        color = KW'(tcolor);
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 3; i++) begin
            bound_coefs[i][0] = CW'($urandom);
            bound_coefs[i][1] = CW'($urandom);
            bound_const[i]    = (2*CW)'($urandom);
        end
        bbox_x0 = CW'($urandom); bbox_x1 = CW'($urandom);
        bbox_y0 = CW'($urandom); bbox_y1 = CW'($urandom);
        winding_any = 1'($urandom);
        color = KW'($urandom);
    endtask

    // Returns at the negedge right after the start-latching edge.
    task automatic launch();
        @(negedge clk);
        apply_tri();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
    endtask

    // Reference model: plain enumeration of the clamped box, direct E evaluation.
    task automatic model_build();
        int x1c, y1c, xs, mask;
        longint e[3];
        bit ge, le;
        exp_addr.delete();
        exp_mask.delete();
        x1c = (tx1 > SX - 1) ? SX - 1 : tx1;
        y1c = (ty1 > SY - 1) ? SY - 1 : ty1;
        xs  = (tx0 / L) * L;
        if (tx0 > x1c || ty0 > y1c) return;
        for (int y = ty0; y <= y1c; y++) begin
            for (int x = xs; x <= x1c; x += L) begin
                mask = 0;
                for (int k = 0; k < L; k++) begin
                    if (x + k >= tx0 && x + k <= x1c) begin
                        for (int i = 0; i < 3; i++)
                            e[i] = longint'(ta[i]) * (x + k) + longint'(tb[i]) * y + longint'(tc[i]);
                        ge = (e[0] >= 0) && (e[1] >= 0) && (e[2] >= 0);
                        le = (e[0] <= 0) && (e[1] <= 0) && (e[2] <= 0);
                        if (ge || (twind && le)) mask |= (1 << k);
                    end
                end
                if (mask != 0) begin
                    exp_addr.push_back(y * SX + x);
                    exp_mask.push_back(mask);
                end
            end
        end
    endtask

    // Drives out_ready and records accepted beats until done or budget.
    // mode 0: ready always high; 1: random ready; 2: ready low 5 cycles after 2nd beat.
    task automatic collect(input int mode, input int budget, output bit done_seen,
                           output int first_edge, output bit hold_bad);
        int edges = 1;
        int stall_left = 0;
        bit stall_used = 0;
        bit prev_stall = 0;
        logic [AW-1:0] pa;
        logic [L-1:0]  pm;
        logic [KW-1:0] pc;
        got_addr.delete(); got_mask.delete(); got_color.delete(); got_edge.delete();
        done_seen = 0; first_edge = -1; hold_bad = 0;
        pa = '0; pm = '0; pc = '0;
        while (edges < budget) begin
            if (prev_stall && (!out_valid || out_addr !== pa || out_mask !== pm || out_color !== pc))
                hold_bad = 1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (got_addr.size() == 2 && !stall_used) begin
                        stall_left = 5; stall_used = 1;
                    end
                    out_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
            endcase
            if (out_valid && first_edge < 0) first_edge = edges;
            if (out_valid && out_ready) begin
                got_addr.push_back(out_addr);
                got_mask.push_back(out_mask);
                got_color.push_back(out_color);
                got_edge.push_back(edges);
                $display("beat addr=%0d mask=%b color=%h edge=%0d", out_addr, out_mask, out_color, edges);
            end
            prev_stall = out_valid && !out_ready;
            pa = out_addr; pm = out_mask; pc = out_color;
            if (done) begin
                done_seen = 1;
                break;
            end
            @(negedge clk);
            edges++;
        end
        out_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 0; abort = 0; out_ready = 1'b1;
        set_tri_flat(0, 0, 0, 0, 0, 0);
        apply_tri();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, out_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, out_valid});
        end
        n_checks++;
        if (out_addr !== '0 || out_mask !== '0 || out_color !== '0) begin
            n_fail++; $display("FAIL reset_data: got addr=%0h mask=%b color=%h expected 0", out_addr, out_mask, out_color);
        end
        reset = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        bit ds, hb; int fe;
        int unsigned ea[4] = '{0, 4, 800, 804};
        set_tri_flat(1, 0, 7, 0, 1, 0);
        launch();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
        collect(0, 200, ds, fe, hb);
        n_checks++;
        if (!ds) begin n_fail++; $display("FAIL basic_done: got no done expected done"); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_in_done: got %b expected 1", busy); end
        n_checks++;
        if (got_addr.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", got_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got_addr.size() || got_addr[i] !== ea[i] || got_mask[i] !== 4'b1111 || got_color[i] !== KW'(tcolor)) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got %0d expected addr=%0d mask=1111", i, (i < got_addr.size()) ? int'(got_addr[i]) : -1, ea[i]);
            end
        end
        n_checks++;
        if (fe < 3) begin n_fail++; $display("FAIL basic_latency: got edge %0d expected >= 3", fe); end
        n_checks++;
        if (got_edge.size() == 4 && got_edge[3] - got_edge[0] != 3) begin
            n_fail++; $display("FAIL basic_throughput: got span %0d expected 3", got_edge[3] - got_edge[0]);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle_after_done: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_edge_skip();
        bit ds, hb; int fe;
        set_tri_flat(1, 0, 7, 0, 0, 0);
        ta[0] = 1; tc[0] = -5;
        launch();
        collect(0, 200, ds, fe, hb);
        n_checks++;
        if (!ds || got_addr.size() != 1 || got_addr[0] !== 32'd4 || got_mask[0] !== 4'b1110) begin
            n_fail++;
            $display("FAIL edge_skip: got done=%b n=%0d addr=%0d mask=%b expected 1 beat addr=4 mask=1110",
                     ds, got_addr.size(), (got_addr.size() > 0) ? int'(got_addr[0]) : -1,
                     (got_mask.size() > 0) ? got_mask[0] : 4'bxxxx);
        end
    endtask

    task automatic test_unaligned();
        bit ds, hb; int fe;
        set_tri_flat(1, 2, 5, 3, 3, 0);
        launch();
        collect(0, 200, ds, fe, hb);
        n_checks++;
        if (!ds || got_addr.size() != 2) begin
            n_fail++; $display("FAIL unaligned_count: got done=%b n=%0d expected done n=2", ds, got_addr.size());
        end else begin
            n_checks++;
            if (got_addr[0] !== 32'd2400 || got_mask[0] !== 4'b1100 || got_addr[1] !== 32'd2404 || got_mask[1] !== 4'b0011) begin
                n_fail++;
                $display("FAIL unaligned_beats: got %0d/%b %0d/%b expected 2400/1100 2404/0011",
                         got_addr[0], got_mask[0], got_addr[1], got_mask[1]);
            end
        end
    endtask

    task automatic test_winding();
        bit ds, hb; int fe;
        set_tri_flat(-1, 0, 3, 0, 0, 0);
        launch();
        collect(0, 200, ds, fe, hb);
        n_checks++;
        if (!ds || got_addr.size() != 0) begin
            n_fail++; $display("FAIL winding0: got done=%b n=%0d expected done n=0", ds, got_addr.size());
        end
        set_tri_flat(-1, 0, 3, 0, 0, 1);
        launch();
        collect(0, 200, ds, fe, hb);
        n_checks++;
        if (!ds || got_addr.size() != 1 || got_addr[0] !== 32'd0 || got_mask[0] !== 4'b1111) begin
            n_fail++; $display("FAIL winding1: got done=%b n=%0d expected 1 beat addr=0 mask=1111", ds, got_addr.size());
        end
    endtask

    task automatic test_stall();
        bit ds, hb; int fe;
        int unsigned ea[4] = '{0, 4, 800, 804};
        set_tri_flat(1, 0, 7, 0, 1, 0);
        launch();
        collect(2, 200, ds, fe, hb);
        n_checks++;
        if (hb) begin n_fail++; $display("FAIL stall_hold: got unstable output expected stable"); end
        n_checks++;
        if (!ds || got_addr.size() != 4) begin
            n_fail++; $display("FAIL stall_count: got done=%b n=%0d expected done n=4", ds, got_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got_addr.size() || got_addr[i] !== ea[i] || got_mask[i] !== 4'b1111) begin
                n_fail++; $display("FAIL stall_beat%0d: got %0d expected %0d", i,
                                   (i < got_addr.size()) ? int'(got_addr[i]) : -1, ea[i]);
            end
        end
    endtask

    task automatic test_abort_misc();
        bit ds, hb, bad; int fe;
        // abort during SCAN
        set_tri_flat(1, 0, 799, 0, 3, 0);
        out_ready = 1'b1;
        launch();
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_wait_valid: got %b expected 1", out_valid); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_stop: got valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || out_valid || busy) bad = 1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL abort_quiet: got activity expected none"); end

        // abort and start together in IDLE: no launch
        @(negedge clk);
        apply_tri();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_same: got busy=%b expected 0", busy); end

        // new start after abort, with a start while busy that must be ignored
        set_tri_flat(1, 0, 7, 0, 0, 0);
        launch();
        apply_tri();
        bbox_x1 = 16'd799; bbox_y1 = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(0, 200, ds, fe, hb);
        n_checks++;
        if (!ds || got_addr.size() != 2 || got_addr[0] !== 32'd0 || got_addr[1] !== 32'd4) begin
            n_fail++; $display("FAIL start_while_busy: got done=%b n=%0d expected done n=2", ds, got_addr.size());
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || out_valid) bad = 1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL start_while_busy_relaunch: got activity expected idle"); end

        // clamping of x1 and y1
        set_tri_flat(1, 796, 900, 598, 700, 0);
        launch();
        collect(0, 200, ds, fe, hb);
        n_checks++;
        if (!ds || got_addr.size() != 2 || got_addr[0] !== 32'd479196 || got_addr[1] !== 32'd479996 ||
            got_mask[0] !== 4'b1111 || got_mask[1] !== 4'b1111) begin
            n_fail++; $display("FAIL clamp: got done=%b n=%0d expected 479196 479996 mask 1111", ds, got_addr.size());
        end

        // empty box
        set_tri_flat(1, 5, 2, 0, 0, 0);
        launch();
        collect(0, 50, ds, fe, hb);
        n_checks++;
        if (!ds || got_addr.size() != 0) begin
            n_fail++; $display("FAIL empty_box: got done=%b n=%0d expected done n=0", ds, got_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        set_tri_flat(1, 0, 799, 0, 3, 0);
        out_ready = 1'b0;
        launch();
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, out_valid} !== 3'b000 || out_addr !== '0 || out_mask !== '0 || out_color !== '0) begin
            n_fail++; $display("FAIL reset_mid: got busy=%b valid=%b addr=%0d expected all 0", busy, out_valid, out_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit ds, hb; int fe, cx, cy, span, bad_beats;
        for (int t = 0; t < 25; t++) begin
            tx0 = int'($urandom_range(0, 815));
            span = int'($urandom_range(0, 26)) - 2;
            tx1 = (tx0 + span < 0) ? 0 : tx0 + span;
            ty0 = int'($urandom_range(0, 603));
            ty1 = ty0 + int'($urandom_range(0, 3));
            cx = tx0 + 10; cy = ty0 + 1;
            for (int i = 0; i < 3; i++) begin
                ta[i] = int'($urandom_range(0, 200)) - 100;
                tb[i] = int'($urandom_range(0, 200)) - 100;
                tc[i] = -(ta[i] * cx + tb[i] * cy) + int'($urandom_range(0, 400)) - 200;
            end
            twind = 1'($urandom);
            tcolor = int'($urandom_range(0, 65535));
            model_build();
            launch();
            collect(1, 1000, ds, fe, hb);
            n_checks++;
            if (!ds || hb || got_addr.size() != exp_addr.size()) begin
                n_fail++;
                $display("FAIL random%0d_count: got done=%b hold_bad=%b n=%0d expected done n=%0d",
                         t, ds, hb, got_addr.size(), exp_addr.size());
            end else begin
                bad_beats = 0;
                for (int i = 0; i < exp_addr.size(); i++)
                    if (got_addr[i] !== AW'(exp_addr[i]) || got_mask[i] !== L'(exp_mask[i]) || got_color[i] !== KW'(tcolor))
                        bad_beats++;
                n_checks++;
                if (bad_beats != 0) begin
                    n_fail++; $display("FAIL random%0d_beats: got %0d wrong beats expected 0", t, bad_beats);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_skip();
        test_unaligned();
        test_winding();
        test_stall();
        test_abort_misc();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
